uart_rx_os: RTL and testbench



---
 rtl/uart_rx_os.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: two-flop synchroniser, mid-bit sampling with
// false-start rejection, optional parity, one or two stop bits, error flags.
module uart_rx_os #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] bdata,
  output logic                 rx_ack,
  output logic                 rx_begin,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int IW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_ZERO      = CW'(0);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_ZERO      = IW'(0);
  localparam logic [IW-1:0] IDX_ONE       = IW'(1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          HAS_PARITY    = (PARITY_EN != 0);
  localparam logic          ODD_PARITY    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  // Expected parity bit for a received data word.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    return (^word) ^ ODD_PARITY;
  endfunction

  logic                 rxd_meta_r, rxd_sync_r, rxd_dly_r;
  logic                 start_cond_s;
  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [IW-1:0]        idx_r, idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 frame_flag_r, frame_flag_s;
  logic                 parity_flag_r, parity_flag_s;
  logic                 sample_s;

  // Input synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_dly_r  <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_dly_r  <= rxd_sync_r;
    end
  end

  assign start_cond_s = rxd_dly_r & ~rxd_sync_r;
  assign sample_s     = (cnt_r == CNT_BIT_LAST);

  // Receiver state, divider, bit index, shift register and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      idx_r         <= IDX_ZERO;
      shift_r       <= '0;
      frame_flag_r  <= 1'b0;
      parity_flag_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      idx_r         <= idx_s;
      shift_r       <= shift_s;
      frame_flag_r  <= frame_flag_s;
      parity_flag_r <= parity_flag_s;
    end
  end

  // Next-state logic; every sampling state waits a full bit period so samples land mid-bit.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    idx_s         = idx_r;
    shift_s       = shift_r;
    frame_flag_s  = frame_flag_r;
    parity_flag_s = parity_flag_r;
    case (state_r)
      IDLE: begin
        if (start_cond_s) begin
          state_s = START;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r;
        end
      end
      START: begin
        if (cnt_r == CNT_HALF_LAST) begin
          cnt_s   = CNT_ZERO;
          idx_s   = IDX_ZERO;
          state_s = rxd_sync_r ? IDLE : DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (sample_s) begin
          cnt_s   = CNT_ZERO;
          shift_s = {rxd_sync_r, shift_r[DATA_BITS-1:1]};
          if (idx_r == IDX_DATA_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = HAS_PARITY ? PARITY : STOP;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      PARITY: begin
        if (sample_s) begin
          cnt_s   = CNT_ZERO;
          state_s = STOP;
          if (rxd_sync_r != parity_bit(shift_r)) begin
            parity_flag_s = 1'b1;
          end else begin
            parity_flag_s = parity_flag_r;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (sample_s) begin
          cnt_s = CNT_ZERO;
          if (!rxd_sync_r) begin
            frame_flag_s = 1'b1;
          end else begin
            frame_flag_s = frame_flag_r;
          end
          if (idx_r == IDX_STOP_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = DONE;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        state_s       = IDLE;
        frame_flag_s  = 1'b0;
        parity_flag_s = 1'b0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Registered outputs: the word and its flags are published together with rx_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bdata      <= '0;
      rx_ack     <= 1'b0;
      rx_begin   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_ack   <= (state_r == DONE);
      rx_begin <= (state_s == START) || (state_s == DATA) ||
                  (state_s == PARITY) || (state_s == STOP);
      if (state_r == DONE) begin
        bdata      <= shift_r;
        frame_err  <= frame_flag_r;
        parity_err <= parity_flag_r;
      end else begin
        bdata      <= bdata;
        frame_err  <= frame_err;
        parity_err <= parity_err;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three configurations (8N1, 8E1, 8O2) fed by a
// frame builder; received words are checked against a per-instance scoreboard.
module tb_uart_rx_os;

  localparam int CLK_DIV = 16;
  localparam int HALF    = CLK_DIV / 2;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       bad_par;
    logic [1:0] stops;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] rxd_v;

  logic [7:0] bdata0, bdata1, bdata2;
  logic       ack0, ack1, ack2;
  logic       beg0, beg1, beg2;
  logic       fe0, fe1, fe2;
  logic       pe0, pe1, pe2;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned begin_cnt0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [7:0]  last_d0;

  uart_rx_os u_dut0 (
    .clk(clk), .rst(rst), .rxd(rxd_v[0]), .bdata(bdata0), .rx_ack(ack0),
    .rx_begin(beg0), .frame_err(fe0), .parity_err(pe0)
  );

  uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .rxd(rxd_v[1]), .bdata(bdata1), .rx_ack(ack1),
    .rx_begin(beg1), .frame_err(fe1), .parity_err(pe1)
  );

  uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .rxd(rxd_v[2]), .bdata(bdata2), .rx_ack(ack2),
    .rx_begin(beg2), .frame_err(fe2), .parity_err(pe2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input exp_t act, input exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got d=%h fe=%b pe=%b, want d=%h fe=%b pe=%b",
               name, act.d, act.fe, act.pe, exp.d, exp.fe, exp.pe);
    end
  endtask

  task automatic unexpected_ack(input string name, input logic [7:0] d);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: rx_ack with d=%h, want no rx_ack", name, d);
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (beg0) begin_cnt0 <= begin_cnt0 + 1;
    if (ack0) begin
      if (q0.size() == 0) unexpected_ack("ack0", bdata0);
      else check_frame("frame0", {bdata0, fe0, pe0}, q0.pop_front());
    end
    if (ack1) begin
      if (q1.size() == 0) unexpected_ack("ack1", bdata1);
      else check_frame("frame1", {bdata1, fe1, pe1}, q1.pop_front());
    end
    if (ack2) begin
      if (q2.size() == 0) unexpected_ack("ack2", bdata2);
      else check_frame("frame2", {bdata2, fe2, pe2}, q2.pop_front());
    end
  end

  task automatic push_exp(input int inst, input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e = {d, fe, pe};
    case (inst)
      0: begin q0.push_back(e); last_d0 = d; end
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic idle_bits(input int nbits);
    repeat (nbits * CLK_DIV) @(negedge clk);
  endtask

  // Builds and drives one frame; abort_bit >= 0 asserts reset mid-way through that frame bit.
  task automatic drive_frame(input int inst, input logic [7:0] d, input logic bad_par,
                             input logic [1:0] stops, input int abort_bit);
    logic [11:0] bits;
    int          n;
    bits    = 12'h000;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (inst != 0) begin
      bits[n] = (^d) ^ (inst == 2) ^ bad_par;
      n++;
    end
    bits[n] = stops[0];
    n++;
    if (inst == 2) begin
      bits[n] = stops[1];
      n++;
    end
    for (int b = 0; b < n; b++) begin
      rxd_v[inst] = bits[b];
      for (int c = 0; c < CLK_DIV; c++) begin
        @(negedge clk);
        if (b == abort_bit && c == HALF) begin
          check("begin_before_reset", {31'd0, beg0}, 32'd1);
          #1 rst = 1'b1;
          #1;
          check("rst_bdata", {24'd0, bdata0}, 32'd0);
          check("rst_ack", {31'd0, ack0}, 32'd0);
          check("rst_begin", {31'd0, beg0}, 32'd0);
          check("rst_ferr", {31'd0, fe0}, 32'd0);
          check("rst_perr", {31'd0, pe0}, 32'd0);
          rxd_v[inst] = 1'b1;
          repeat (3) @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
    end
    rxd_v[inst] = 1'b1;
  endtask

  vec_t        vecs[10];
  int unsigned snap;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    begin_cnt0 = 0;
    last_d0    = 8'h00;
    rst        = 1'b1;
    rxd_v      = 3'b111;

    vecs[0] = '{0, 8'h55, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[1] = '{0, 8'hA6, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[2] = '{0, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[3] = '{0, 8'hFF, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[4] = '{0, 8'h3C, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[5] = '{1, 8'hA3, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[6] = '{1, 8'hA3, 1'b1, 2'b11, 1'b0, 1'b1};
    vecs[7] = '{1, 8'h5A, 1'b0, 2'b10, 1'b1, 1'b0};
    vecs[8] = '{2, 8'hC5, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[9] = '{2, 8'h7F, 1'b1, 2'b11, 1'b0, 1'b1};

    repeat (4) @(negedge clk);
    check("reset_bdata", {24'd0, bdata0}, 32'd0);
    check("reset_ack", {31'd0, ack0}, 32'd0);
    check("reset_begin", {31'd0, beg0}, 32'd0);
    check("reset_ferr", {31'd0, fe0}, 32'd0);
    check("reset_perr", {31'd0, pe1}, 32'd0);
    rst = 1'b0;
    idle_bits(1);

    for (int v = 0; v < 10; v++) begin
      push_exp(vecs[v].inst, vecs[v].d, vecs[v].exp_fe, vecs[v].exp_pe);
      drive_frame(vecs[v].inst, vecs[v].d, vecs[v].bad_par, vecs[v].stops, -1);
      idle_bits(2);
    end
    check("table_q0_drained", q0.size(), 32'd0);
    check("table_q1_drained", q1.size(), 32'd0);
    check("table_q2_drained", q2.size(), 32'd0);

    // rx_begin length for 8N1: HALF + 9 bit periods.
    snap = begin_cnt0;
    push_exp(0, 8'h55, 1'b0, 1'b0);
    drive_frame(0, 8'h55, 1'b0, 2'b11, -1);
    idle_bits(2);
    check("begin_len_8n1", begin_cnt0 - snap, HALF + 9 * CLK_DIV);

    // Glitch shorter than half a bit: START only, no rx_ack.
    snap = begin_cnt0;
    rxd_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd_v[0] = 1'b1;
    idle_bits(2);
    check("glitch_begin_len", begin_cnt0 - snap, HALF);
    check("glitch_bdata_kept", {24'd0, bdata0}, {24'd0, last_d0});

    // Break: line low for two frame times gives exactly one errored frame.
    push_exp(0, 8'h00, 1'b1, 1'b0);
    rxd_v[0] = 1'b0;
    repeat (2 * 10 * CLK_DIV) @(negedge clk);
    check("break_q0_drained", q0.size(), 32'd0);
    rxd_v[0] = 1'b1;
    idle_bits(3);

    // Reset during data bit 3 of 0x81, then a clean 0x3C.
    drive_frame(0, 8'h81, 1'b0, 2'b11, 4);
    idle_bits(2);
    push_exp(0, 8'h3C, 1'b0, 1'b0);
    drive_frame(0, 8'h3C, 1'b0, 2'b11, -1);
    idle_bits(2);
    check("after_reset_q0_drained", q0.size(), 32'd0);
    check("after_reset_bdata", {24'd0, bdata0}, 32'h3C);

    // 8O2: low second stop bit, then two frames with no idle gap.
    push_exp(2, 8'h12, 1'b1, 1'b0);
    drive_frame(2, 8'h12, 1'b0, 2'b01, -1);
    idle_bits(1);
    push_exp(2, 8'h34, 1'b0, 1'b0);
    push_exp(2, 8'h56, 1'b0, 1'b0);
    drive_frame(2, 8'h34, 1'b0, 2'b11, -1);
    drive_frame(2, 8'h56, 1'b0, 2'b11, -1);
    idle_bits(3);
    check("b2b_q2_drained", q2.size(), 32'd0);
    check("b2b_ferr_cleared", {31'd0, fe2}, 32'd0);

    check("final_q0_drained", q0.size(), 32'd0);
    check("final_q1_drained", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
